spgd_adc_accum: RTL

Upstream feeder of the SPGD sequencing FSM. Takes the ADC sample stream and, while the FSM holds ADC_EN high, discards a settling window and then accumulates 2^LOG2_N samples. It then asserts ADC_DONE and presents the metric J as a sum and a mean. The J_P/J_M write logic captures J_MEAN; J_MEAN is held stable while ADC_EN stays high through the FSM's MATH and write states.

---
 rtl/spgd_adc_accum_pkg.sv | 19 +
 rtl/spgd_adc_accum_if.sv | 27 ++
 rtl/spgd_sample_counter.sv | 30 +++
 rtl/spgd_adc_accum.sv | 137 +++++++++++++
 4 files changed

// File: rtl/spgd_adc_accum_pkg.sv
// Shared encodings and constants for the SPGD ADC accumulator.
// ACC_STATE values are decoded by the sequencing FSM and GPIO readback.
package spgd_pkg;

   localparam int ADC_WIDTH_DEF = 14;

   typedef enum logic [1:0] {
      ACC_IDLE   = 2'd0,
      ACC_SETTLE = 2'd1,
      ACC_ACCUM  = 2'd2,
      ACC_DONE   = 2'd3
   } acc_state_e;

   localparam logic signed [ADC_WIDTH_DEF-1:0] FS_POS_DEF =
      {1'b0, {(ADC_WIDTH_DEF-1){1'b1}}};
   localparam logic signed [ADC_WIDTH_DEF-1:0] FS_NEG_DEF =
      {1'b1, {(ADC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/spgd_adc_accum_if.sv
// ADC sample stream in, measurement result out.
// master = sequencing FSM side, slave = accumulator.
interface spgd_adc_accum_if #(
   parameter int ADC_WIDTH = 14,
   parameter int LOG2_N    = 6
);

   logic                                ADC_EN;
   logic                                ADC_VALID;
   logic signed [ADC_WIDTH-1:0]         ADC_DATA;
   logic                                ADC_DONE;
   logic signed [ADC_WIDTH+LOG2_N-1:0]  J_SUM;
   logic signed [ADC_WIDTH-1:0]         J_MEAN;
   logic                                CLIP;
   logic [1:0]                          ACC_STATE;

   modport master (
      output ADC_EN, ADC_VALID, ADC_DATA,
      input  ADC_DONE, J_SUM, J_MEAN, CLIP, ACC_STATE
   );

   modport slave (
      input  ADC_EN, ADC_VALID, ADC_DATA,
      output ADC_DONE, J_SUM, J_MEAN, CLIP, ACC_STATE
   );

endinterface

// File: rtl/spgd_sample_counter.sv
// Loadable up-counter; tc flags the increment that reaches term.
// Used for both the settle count and the sample count.
module spgd_sample_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;

   assign cnt_nxt = cnt + W'(1);
   assign tc      = inc && (cnt_nxt == term);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (inc)
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/spgd_adc_accum.sv
// ADC metric accumulator: settle, sum 2^LOG2_N samples, hold J until
// the sequencing FSM drops ADC_EN.
module spgd_adc_accum
   import spgd_pkg::*;
#(
   parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
   parameter int LOG2_N       = 6,
   parameter int SETTLE       = 4,
   parameter int SETTLE_WIDTH = 8
) (
   input  logic               ADC_CLK,
   input  logic               RST,
   spgd_adc_accum_if.slave    bus
);

   localparam int AW = ADC_WIDTH + LOG2_N;
   localparam int CW = LOG2_N + 1;

   localparam logic signed [ADC_WIDTH-1:0] FS_POS =
      {1'b0, {(ADC_WIDTH-1){1'b1}}};
   localparam logic signed [ADC_WIDTH-1:0] FS_NEG =
      {1'b1, {(ADC_WIDTH-1){1'b0}}};

   localparam logic [CW-1:0] N_TERM = CW'(1) << LOG2_N;
   localparam logic [SETTLE_WIDTH-1:0] S_TERM =
      SETTLE_WIDTH'(SETTLE);

   acc_state_e                  state;
   logic signed [AW-1:0]        acc;
   logic                        clip_q;
   logic                        done_q;
   logic signed [AW-1:0]        j_sum_q;
   logic signed [ADC_WIDTH-1:0] j_mean_q;
   logic                        clip_o;

   logic                        en;
   logic                        vld;
   logic signed [ADC_WIDTH-1:0] din;
   logic signed [AW-1:0]        smp;
   logic signed [AW-1:0]        sum;
   logic signed [ADC_WIDTH-1:0] mean;
   logic                        smp_clip;
   logic                        cnt_load;
   logic                        st_inc;
   logic                        st_tc;
   logic                        n_inc;
   logic                        n_tc;

   assign en       = bus.ADC_EN;
   assign vld      = bus.ADC_VALID;
   assign din      = bus.ADC_DATA;
   assign smp      = AW'(din);
   assign sum      = acc + smp;
   assign mean     = ADC_WIDTH'(sum >>> LOG2_N);
   assign smp_clip = (din == FS_POS) || (din == FS_NEG);

   assign cnt_load = (state == ACC_IDLE);
   assign st_inc   = (state == ACC_SETTLE) && en && vld;
   assign n_inc    = (state == ACC_ACCUM) && en && vld;

   spgd_sample_counter #(.W(SETTLE_WIDTH)) u_settle_cnt (
      .clk      (ADC_CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val ('0),
      .inc      (st_inc),
      .term     (S_TERM),
      .tc       (st_tc)
   );

   spgd_sample_counter #(.W(CW)) u_sample_cnt (
      .clk      (ADC_CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val ('0),
      .inc      (n_inc),
      .term     (N_TERM),
      .tc       (n_tc)
   );

   always_ff @(posedge ADC_CLK) begin
      if (RST) begin
         state    <= ACC_IDLE;
         acc      <= '0;
         clip_q   <= 1'b0;
         done_q   <= 1'b0;
         j_sum_q  <= '0;
         j_mean_q <= '0;
         clip_o   <= 1'b0;
      end else begin
         unique case (state)
            ACC_IDLE: begin
               acc    <= '0;
               clip_q <= 1'b0;
               done_q <= 1'b0;
               if (en)
                  state <= (SETTLE == 0) ? ACC_ACCUM : ACC_SETTLE;
            end
            ACC_SETTLE: begin
               if (!en)
                  state <= ACC_IDLE;
               else if (st_tc)
                  state <= ACC_ACCUM;
            end
            ACC_ACCUM: begin
               if (!en) begin
                  state <= ACC_IDLE;
               end else if (n_tc) begin
                  j_sum_q  <= sum;
                  j_mean_q <= mean;
                  clip_o   <= clip_q | smp_clip;
                  done_q   <= 1'b1;
                  state    <= ACC_DONE;
               end else if (vld) begin
                  acc    <= sum;
                  clip_q <= clip_q | smp_clip;
               end
            end
            ACC_DONE: begin
               // results stay frozen until the FSM releases ADC_EN
               if (!en) begin
                  done_q <= 1'b0;
                  state  <= ACC_IDLE;
               end
            end
            default: state <= ACC_IDLE;
         endcase
      end
   end

   assign bus.ADC_DONE  = done_q;
   assign bus.J_SUM     = j_sum_q;
   assign bus.J_MEAN    = j_mean_q;
   assign bus.CLIP      = clip_o;
   assign bus.ACC_STATE = state;

endmodule
